// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states,
// opcodes, datapath mux selects and the packed control word.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC      = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_ADDI_EX   = 4'd9,
      S_ADDI_WB   = 4'd10,
      S_JUMP      = 4'd11,
      S_HALT      = 4'd15
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_BGTZ = 6'b000111;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       branch_gz;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       halted;
   } ctrl_t;

   // First execution state for an opcode seen in DECODE; undefined opcodes map to HALT.
   function automatic state_t dispatch(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW:          return S_MEM_ADDR;
         OP_R:                  return S_EXEC;
         OP_BEQ, OP_BNE, OP_BGTZ: return S_BRANCH;
         OP_ADDI:               return S_ADDI_EX;
         OP_J:                  return S_JUMP;
         default:               return S_HALT;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore control-word decode: state (plus latched opcode for branch flavour
// and mem_ready for the FETCH write gating) -> every datapath mux/enable.
module mc_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  op_q,
   input  logic        mem_ready,
   output ctrl_t       ctrl
);

   // Control word per state; everything not named in a state stays 0.
   always_comb begin
      // NOTE: the all-zero default before the case keeps every field assigned on
      // every path, so no latch is inferred for the fields a state leaves alone.
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.branch_ne     = (op_q == OP_BNE);
            ctrl.branch_gz     = (op_q == OP_BGTZ);
         end
         S_ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         default: begin
            // HALT and the unused encodings 12-14 all behave as HALT.
            ctrl.halted = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: state register,
// latched opcode, next-state sequencing and the retired-instruction counter.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W           = 32,
   parameter int HALT_ON_ILLEGAL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             Branch_ne,
   output logic             Branch_gz,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count,
   output logic             halted
);

   state_t     state_q;
   state_t     state_d;
   logic [5:0] op_q;
   logic       done;
   ctrl_t      ctrl;

   // Next state and retire pulse; wait states simply hold state_q.
   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         S_FETCH:     if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            state_d = dispatch(opcode);
            if (state_d == S_HALT && HALT_ON_ILLEGAL == 0) begin
               // Undefined opcode retired as a NOP.
               state_d = S_FETCH;
               done    = 1'b1;
            end
         end
         S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               done    = 1'b1;
            end
         end
         S_EXEC:      state_d = S_R_WB;
         S_ADDI_EX:   state_d = S_ADDI_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB, S_JUMP: begin
            state_d = S_FETCH;
            done    = 1'b1;
         end
         default:     state_d = S_HALT;
      endcase
   end

   // State register, opcode latch and retire counter; reset abandons any instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FETCH;
         op_q        <= '0;
         instr_count <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
         if (done) instr_count <= instr_count + CNT_W'(1);
      end
   end

   mc_ctrl_decode u_decode (
      .state     (state_q),
      .op_q      (op_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign Branch_ne   = ctrl.branch_ne;
   assign Branch_gz   = ctrl.branch_gz;
   assign IorD        = ctrl.i_or_d;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ALUOp       = ctrl.alu_op;
   assign PCSource    = ctrl.pc_source;
   assign halted      = ctrl.halted;
   assign state       = state_q;
   assign instr_done  = done;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one halting instance (CNT_W=32) and one
// NOP-on-illegal instance with a 2-bit counter to exercise wraparound.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;

   logic        PCWrite, PCWriteCond, Branch_ne, Branch_gz, IorD, MemRead, MemWrite;
   logic        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, halted;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic [3:0]  state;
   logic [31:0] instr_count;

   logic        n_PCWrite, n_PCWriteCond, n_Branch_ne, n_Branch_gz, n_IorD, n_MemRead, n_MemWrite;
   logic        n_IRWrite, n_MemtoReg, n_RegDst, n_RegWrite, n_ALUSrcA, n_instr_done, n_halted;
   logic [1:0]  n_ALUSrcB, n_ALUOp, n_PCSource;
   logic [3:0]  n_state;
   logic [1:0]  n_instr_count;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch_ne(Branch_ne),
      .Branch_gz(Branch_gz), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .state(state), .instr_done(instr_done), .instr_count(instr_count), .halted(halted)
   );

   multicycle_ctrl #(.CNT_W(2), .HALT_ON_ILLEGAL(0)) dut_nop (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .Branch_ne(n_Branch_ne),
      .Branch_gz(n_Branch_gz), .IorD(n_IorD), .MemRead(n_MemRead), .MemWrite(n_MemWrite),
      .IRWrite(n_IRWrite), .MemtoReg(n_MemtoReg), .RegDst(n_RegDst), .RegWrite(n_RegWrite),
      .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp), .PCSource(n_PCSource),
      .state(n_state), .instr_done(n_instr_done), .instr_count(n_instr_count), .halted(n_halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; outputs are examined 2 time units after the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst       = 1'b1;
      opcode    = 6'b000000;
      mem_ready = 1'b1;
      #12;
      // Reset state: FETCH control word.
      check("rst_state", 32'(state), 32'd0);
      check("rst_count", instr_count, 32'd0);
      check("rst_memread", 32'(MemRead), 32'd1);
      check("rst_srcb", 32'(ALUSrcB), 32'b01);
      check("rst_iord", 32'(IorD), 32'd0);
      rst = 1'b0;
      #1;

      // add: 0,1,6,7 with retire in state 7.
      check("add_f_irwrite", 32'(IRWrite), 32'd1);
      check("add_f_pcwrite", 32'(PCWrite), 32'd1);
      check("add_f_done", 32'(instr_done), 32'd0);
      opcode = 6'b000000;
      step(); check("add_s1", 32'(state), 32'd1);
      check("add_dec_srcb", 32'(ALUSrcB), 32'b11);
      step(); check("add_s6", 32'(state), 32'd6);
      check("add_exec_aluop", 32'(ALUOp), 32'b10);
      check("add_exec_srca", 32'(ALUSrcA), 32'd1);
      step(); check("add_s7", 32'(state), 32'd7);
      check("add_regwrite", 32'(RegWrite), 32'd1);
      check("add_regdst", 32'(RegDst), 32'd1);
      check("add_done", 32'(instr_done), 32'd1);
      step(); exp_cnt++;
      check("add_back_fetch", 32'(state), 32'd0);
      check("add_count", instr_count, 32'(exp_cnt));

      // FETCH stall: no IR/PC write while memory not ready.
      mem_ready = 1'b0; #1;
      check("fstall_irwrite", 32'(IRWrite), 32'd0);
      check("fstall_pcwrite", 32'(PCWrite), 32'd0);
      check("fstall_memread", 32'(MemRead), 32'd1);
      step(); check("fstall_hold", 32'(state), 32'd0);
      mem_ready = 1'b1;

      // lw with 3 wait cycles in MEM_READ.
      opcode = 6'b100011;
      step(); check("lw_s1", 32'(state), 32'd1);
      step(); check("lw_s2", 32'(state), 32'd2);
      check("lw_addr_srcb", 32'(ALUSrcB), 32'b10);
      mem_ready = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         check("lw_wait_state", 32'(state), 32'd3);
         check("lw_wait_memread", 32'(MemRead), 32'd1);
         check("lw_wait_iord", 32'(IorD), 32'd1);
         step();
      end
      mem_ready = 1'b1; #1;
      check("lw_last_state", 32'(state), 32'd3);
      step(); check("lw_s4", 32'(state), 32'd4);
      check("lw_regwrite", 32'(RegWrite), 32'd1);
      check("lw_memtoreg", 32'(MemtoReg), 32'd1);
      check("lw_regdst", 32'(RegDst), 32'd0);
      check("lw_done", 32'(instr_done), 32'd1);
      step(); exp_cnt++;
      check("lw_count", instr_count, 32'(exp_cnt));

      // sw with one wait cycle in MEM_WRITE.
      opcode = 6'b101011;
      step(); step(); step();
      check("sw_s5", 32'(state), 32'd5);
      check("sw_memwrite", 32'(MemWrite), 32'd1);
      mem_ready = 1'b0; #1;
      check("sw_wait_done", 32'(instr_done), 32'd0);
      step(); check("sw_hold", 32'(state), 32'd5);
      check("sw_hold_memwrite", 32'(MemWrite), 32'd1);
      mem_ready = 1'b1; #1;
      check("sw_done", 32'(instr_done), 32'd1);
      step(); exp_cnt++;
      check("sw_fetch", 32'(state), 32'd0);
      check("sw_count", instr_count, 32'(exp_cnt));

      // bne then bgtz.
      opcode = 6'b000101;
      step(); step();
      check("bne_s8", 32'(state), 32'd8);
      check("bne_pcwc", 32'(PCWriteCond), 32'd1);
      check("bne_pcsrc", 32'(PCSource), 32'b01);
      check("bne_ne", 32'(Branch_ne), 32'd1);
      check("bne_gz", 32'(Branch_gz), 32'd0);
      check("bne_aluop", 32'(ALUOp), 32'b01);
      check("bne_done", 32'(instr_done), 32'd1);
      step(); exp_cnt++;
      check("bne_count", instr_count, 32'(exp_cnt));
      opcode = 6'b000111;
      step(); step();
      check("bgtz_s8", 32'(state), 32'd8);
      check("bgtz_gz", 32'(Branch_gz), 32'd1);
      check("bgtz_ne", 32'(Branch_ne), 32'd0);
      step(); exp_cnt++;
      check("bgtz_count", instr_count, 32'(exp_cnt));

      // addi: 0,1,9,10.
      opcode = 6'b001000;
      step(); step();
      check("addi_s9", 32'(state), 32'd9);
      step();
      check("addi_s10", 32'(state), 32'd10);
      check("addi_regwrite", 32'(RegWrite), 32'd1);
      check("addi_regdst", 32'(RegDst), 32'd0);
      step(); exp_cnt++;
      check("addi_count", instr_count, 32'(exp_cnt));

      // j: 0,1,11.
      opcode = 6'b000010;
      step(); step();
      check("j_s11", 32'(state), 32'd11);
      check("j_pcwrite", 32'(PCWrite), 32'd1);
      check("j_pcsrc", 32'(PCSource), 32'b10);
      step(); exp_cnt++;
      check("j_count", instr_count, 32'(exp_cnt));
      check("j_fetch", 32'(state), 32'd0);

      // Async reset in the middle of a stalled lw.
      opcode = 6'b100011;
      step(); step(); mem_ready = 1'b0; step();
      check("rlw_s3", 32'(state), 32'd3);
      rst = 1'b1; #1;
      check("rlw_state", 32'(state), 32'd0);
      check("rlw_count", instr_count, 32'd0);
      check("rlw_memwrite", 32'(MemWrite), 32'd0);
      check("rlw_nop_count", 32'(n_instr_count), 32'd0);
      #1; rst = 1'b0; mem_ready = 1'b1;
      @(negedge clk);

      // Illegal opcode: halting instance sticks in HALT, NOP instance retires it.
      opcode = 6'b111111;
      step(); check("ill_s1", 32'(state), 32'd1);
      check("ill_halt_done", 32'(instr_done), 32'd0);
      check("ill_nop_done", 32'(n_instr_done), 32'd1);
      step();
      check("ill_halt_state", 32'(state), 32'd15);
      check("ill_nop_state", 32'(n_state), 32'd0);
      check("ill_nop_count", 32'(n_instr_count), 32'd1);
      for (int i = 0; i < 20; i++) begin
         check("halt_hold", 32'(halted), 32'd1);
         check("halt_state", 32'(state), 32'd15);
         check("halt_memread", 32'(MemRead), 32'd0);
         step();
      end
      check("halt_count", instr_count, 32'd0);
      // NOP instance retired one more illegal opcode every 2 cycles: 1+10 = 11 mod 4.
      check("nop_count_mod", 32'(n_instr_count), 32'd3);
      check("nop_state", 32'(n_state), 32'd0);
      step(); step();
      check("nop_wrap", 32'(n_instr_count), 32'd0);
      check("nop_not_halted", 32'(n_halted), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
